// File: rtl/ppu_oam_scan.sv
// OAM sprite scanner: walks every OAM entry once per line and buffers the first
// MAX_PER_LINE sprites that overlap the requested line.
module ppu_oam_scan #(
    parameter int SPRITE_COUNT = 40,
    parameter int MAX_PER_LINE = 10,
    parameter int IDX_W        = 6,
    parameter int CNT_W        = 4
) (
    input  logic             clockgb,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       line,
    input  logic             tall,
    output logic [IDX_W-1:0] oam_addr,
    input  logic [7:0]       oam_y,
    input  logic [7:0]       oam_x,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic [CNT_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [7:0]       rd_x,
    output logic [IDX_W-1:0] rd_id,
    output logic [3:0]       rd_row
);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             eval_vld_q;
    logic [IDX_W-1:0] eval_id_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic [7:0]       line_q;
    logic             tall_q;

    logic [7:0]       buf_x   [MAX_PER_LINE];
    logic [IDX_W-1:0] buf_id  [MAX_PER_LINE];
    logic [3:0]       buf_row [MAX_PER_LINE];

    logic [8:0] line16, y9, y_end;
    logic       hit, has_room;
    logic [3:0] row;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StScan;
            StScan:  if (idx_q == IDX_W'(SPRITE_COUNT - 1)) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q == StScan) || (state_q == StDrain);
    assign done     = (state_q == StDone);
    assign oam_addr = (state_q == StScan) ? idx_q : '0;
    assign count    = count_q;
    assign overflow = ovf_q;

    // 9-bit compare so sprites near the bottom do not wrap around
    always_comb begin
        line16   = {1'b0, line_q} + 9'd16;
        y9       = {1'b0, oam_y};
        y_end    = y9 + (tall_q ? 9'd16 : 9'd8);
        hit      = eval_vld_q && (line16 >= y9) && (line16 < y_end);
        has_room = count_q < CNT_W'(MAX_PER_LINE);
        // low nibble of (line+16-y) equals low nibble of (line-y)
        row      = line_q[3:0] - oam_y[3:0];
    end

    always_ff @(posedge clockgb) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            eval_vld_q <= 1'b0;
            eval_id_q  <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            line_q     <= '0;
            tall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            // data for the address presented now arrives next cycle
            eval_vld_q <= (state_q == StScan);
            eval_id_q  <= idx_q;
            if (state_q == StIdle && start) begin
                line_q  <= line;
                tall_q  <= tall;
                count_q <= '0;
                ovf_q   <= 1'b0;
                idx_q   <= '0;
            end else if (state_q == StScan) begin
                idx_q <= idx_q + 1'b1;
            end
            if (hit) begin
                if (has_room) count_q <= count_q + 1'b1;
                else          ovf_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clockgb) begin
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (hit && has_room && count_q == CNT_W'(i)) begin
                buf_x[i]   <= oam_x;
                buf_id[i]  <= eval_id_q;
                buf_row[i] <= row;
            end
        end
    end

    always_comb begin
        rd_valid = rd_idx < count_q;
        rd_x     = '0;
        rd_id    = '0;
        rd_row   = '0;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (rd_valid && rd_idx == CNT_W'(i)) begin
                rd_x   = buf_x[i];
                rd_id  = buf_id[i];
                rd_row = buf_row[i];
            end
        end
    end

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Directed bench for ppu_oam_scan with a one-cycle-latency OAM memory model.
module tb_ppu_oam_scan;

    logic       clockgb = 1'b0;
    logic       reset, start, tall;
    logic [7:0] line;
    logic [5:0] oam_addr;
    logic [7:0] oam_y = 8'd0, oam_x = 8'd0;
    logic       busy, done, overflow, rd_valid;
    logic [3:0] count, rd_idx, rd_row;
    logic [7:0] rd_x;
    logic [5:0] rd_id;

    logic [7:0] mem_y [64];
    logic [7:0] mem_x [64];

    int total = 0;
    int bad   = 0;
    int done_cyc, pulses;

    ppu_oam_scan dut (
        .clockgb  (clockgb),
        .reset    (reset),
        .start    (start),
        .line     (line),
        .tall     (tall),
        .oam_addr (oam_addr),
        .oam_y    (oam_y),
        .oam_x    (oam_x),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_x     (rd_x),
        .rd_id    (rd_id),
        .rd_row   (rd_row)
    );

    always #5 clockgb = ~clockgb;

    always @(posedge clockgb) begin
        oam_y <= mem_y[oam_addr];
        oam_x <= mem_x[oam_addr];
    end

    task automatic tick();
        @(posedge clockgb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem_y[i] = 8'd0;
            mem_x[i] = 8'd0;
        end
    endtask

    task automatic read_slot(input logic [3:0] s, input logic [7:0] ex, input logic [5:0] eid,
                             input logic [3:0] erow);
        rd_idx = s;
        #1;
        chk("slot_valid", rd_valid, 1);
        chk("slot_x", rd_x, ex);
        chk("slot_id", rd_id, eid);
        chk("slot_row", rd_row, erow);
        rd_idx = 4'd0;
    endtask

    // Cycle 0 is the current cycle; restart_at re-pulses start while busy.
    task automatic run_scan(input logic [7:0] l, input logic t, input int restart_at);
        line     = l;
        tall     = t;
        start    = 1'b1;
        done_cyc = -1;
        pulses   = 0;
        tick();
        for (int c = 1; c <= 60; c++) begin
            start = (c == restart_at);
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 1)  chk("addr_c1", oam_addr, 0);
            if (c == 1)  chk("busy_c1", busy, 1);
            if (c == 40) chk("addr_c40", oam_addr, 39);
            if (c == 41) chk("addr_drain", oam_addr, 0);
            if (c == 41) chk("busy_drain", busy, 1);
            if (c == 43) chk("busy_after", busy, 0);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        line   = 8'd0;
        tall   = 1'b0;
        rd_idx = 4'd0;
        clear_mem();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", oam_addr, 0);
        chk("rst_rdvalid", rd_valid, 0);
        start = 1'b1;
        tick();
        chk("rst_over_start", busy, 0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        // single sprite at the top of line 0
        mem_y[0] = 8'd16;
        mem_x[0] = 8'd8;
        run_scan(8'd0, 1'b0, 0);
        chk("t1_done_cyc", done_cyc, 42);
        chk("t1_pulses", pulses, 1);
        chk("t1_count", count, 1);
        chk("t1_ovf", overflow, 0);
        read_slot(4'd0, 8'd8, 6'd0, 4'd0);
        rd_idx = 4'd1;
        #1;
        chk("t1_slot1_valid", rd_valid, 0);
        chk("t1_slot1_x", rd_x, 0);
        rd_idx = 4'd0;

        // twelve hits, buffer saturates at ten
        clear_mem();
        for (int i = 0; i < 12; i++) begin
            mem_y[i] = 8'd20;
            mem_x[i] = 8'(100 + i);
        end
        run_scan(8'd10, 1'b0, 0);
        chk("t2_count", count, 10);
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 10; i++) read_slot(4'(i), 8'(100 + i), 6'(i), 4'd6);
        rd_idx = 4'd10;
        #1;
        chk("t2_slot10_valid", rd_valid, 0);
        rd_idx = 4'd0;

        // tall vs short height
        clear_mem();
        mem_y[5] = 8'd16;
        mem_x[5] = 8'd55;
        run_scan(8'd12, 1'b0, 0);
        chk("t3_short_count", count, 0);
        chk("t3_ovf_cleared", overflow, 0);
        run_scan(8'd12, 1'b1, 0);
        chk("t3_tall_count", count, 1);
        read_slot(4'd0, 8'd55, 6'd5, 4'd12);

        // edges of the 8-line window and y=0 in tall mode
        clear_mem();
        mem_y[3] = 8'd16;
        mem_x[3] = 8'd33;
        run_scan(8'd7, 1'b0, 0);
        chk("t4_last_row_count", count, 1);
        read_slot(4'd0, 8'd33, 6'd3, 4'd7);
        run_scan(8'd8, 1'b0, 0);
        chk("t4_past_end_count", count, 0);
        clear_mem();
        run_scan(8'd0, 1'b1, 0);
        chk("t4_y0_tall_count", count, 0);

        // reset in cycle 20 aborts the scan
        clear_mem();
        mem_y[0] = 8'd16;
        mem_x[0] = 8'd8;
        line   = 8'd0;
        tall   = 1'b0;
        start  = 1'b1;
        pulses = 0;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (done) pulses++;
            tick();
        end
        chk("t5_count_c20", count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy_c21", busy, 0);
        chk("t5_done_c21", done, 0);
        chk("t5_count_c21", count, 0);
        chk("t5_rdvalid_c21", rd_valid, 0);
        for (int c = 0; c < 40; c++) begin
            if (done) pulses++;
            tick();
        end
        chk("t5_no_done", pulses, 0);
        run_scan(8'd0, 1'b0, 0);
        chk("t5_restart_done", done_cyc, 42);
        chk("t5_restart_count", count, 1);

        // start re-pulsed while busy is ignored
        run_scan(8'd0, 1'b0, 10);
        chk("t6_done_cyc", done_cyc, 42);
        chk("t6_pulses", pulses, 1);
        chk("t6_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
